// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multi-cycle MIPS control FSM (fetch/decode/execute/memory/writeback sequencing)
module mips_multicycle_control #(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_R_EXEC    = 4'd7,
      S_R_WB      = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_ADDI_EXEC = 4'd11,
      S_ADDI_WB   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   state_t state_q;
   state_t state_d;
   logic   mem_ok;

   // With waiting disabled every memory access is treated as completing immediately.
   assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

   assign state = state_q;

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection: memory states hold until the access completes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      state_d = S_FETCH;
         S_FETCH:     state_d = mem_ok ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:      state_d = S_R_EXEC;
               OP_LW, OP_SW:  state_d = S_MEM_ADDR;
               OP_BEQ:        state_d = S_BRANCH;
               OP_J:          state_d = S_JUMP;
               OP_ADDI:       state_d = S_ADDI_EXEC;
               default:       state_d = S_FETCH;
            endcase
         end
         S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  state_d = mem_ok ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: state_d = mem_ok ? S_FETCH : S_MEM_WRITE;
         S_R_EXEC:    state_d = S_R_WB;
         S_R_WB:      state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
         S_ADDI_EXEC: state_d = S_ADDI_WB;
         S_ADDI_WB:   state_d = S_FETCH;
         default:     state_d = S_FETCH;
      endcase
   end

   // Moore control decode; only FETCH looks at mem_ready and only DECODE looks at opcode.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ALUOp       = ALU_ADD;
      PCSource    = PCSRC_ALU;
      illegal_op  = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead  = 1'b1;
            ALUSrcB  = SRCB_FOUR;
            IRWrite  = mem_ok;
            PCWrite  = mem_ok;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            case (opcode)
               OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
               default:                                        illegal_op = 1'b1;
            endcase
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEM_WRITE: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_R_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_FUNCT;
         end
         S_R_WB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         S_ADDI_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_ADDI_WB: begin
            RegWrite = 1'b1;
         end
         default: begin
            PCWrite = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - directed-vector bench for mips_multicycle_control
module tb_mips_multicycle_control;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;

   int tests_run;
   int tests_failed;

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] RTY  = 6'b000000;
   localparam logic [5:0] BAD  = 6'b111111;

   mips_multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
   );

   logic [16:0] ctrl;
   assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected control word per state, written from the state table.
   function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy, input logic ill);
      logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, srca;
      logic [1:0] srcb, aop, pcs;
      pcw = 0; pcwc = 0; iord = 0; mr = 0; mw = 0; irw = 0; m2r = 0; rd = 0; rw = 0; srca = 0;
      srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
      case (st)
         4'd1:  begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
         4'd2:  begin srcb = 2'b11; end
         4'd3:  begin srca = 1; srcb = 2'b10; end
         4'd4:  begin mr = 1; iord = 1; end
         4'd5:  begin rw = 1; m2r = 1; end
         4'd6:  begin mw = 1; iord = 1; end
         4'd7:  begin srca = 1; aop = 2'b10; end
         4'd8:  begin rw = 1; rd = 1; end
         4'd9:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         4'd10: begin pcw = 1; pcs = 2'b10; end
         4'd11: begin srca = 1; srcb = 2'b10; end
         4'd12: begin rw = 1; end
         default: begin pcw = 0; end
      endcase
      return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, srca, srcb, aop, pcs, ill};
   endfunction

   // One cycle: apply inputs at the falling edge, then check state and outputs.
   task automatic step(input string tag, input logic [5:0] op, input logic rdy,
                       input logic [3:0] exp_st, input logic exp_ill);
      @(negedge clk);
      opcode    = op;
      mem_ready = rdy;
      #1;
      check({tag, ".state"}, 32'(state), 32'(exp_st));
      check({tag, ".ctrl"}, 32'(ctrl), 32'(exp_ctrl(exp_st, rdy, exp_ill)));
      check({tag, ".rd_wr_excl"}, 32'(MemRead & MemWrite), 32'd0);
      check({tag, ".rw_pcw_excl"}, 32'(RegWrite & PCWrite), 32'd0);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      opcode       = 6'd0;
      mem_ready    = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("reset.state", 32'(state), 32'd0);
      check("reset.ctrl", 32'(ctrl), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("release.idle", 32'(state), 32'd0);

      // lw with memory always ready
      step("lw.f",  LW, 1'b1, 4'd1, 1'b0);
      step("lw.d",  LW, 1'b1, 4'd2, 1'b0);
      step("lw.a",  LW, 1'b1, 4'd3, 1'b0);
      step("lw.r",  LW, 1'b1, 4'd4, 1'b0);
      step("lw.wb", LW, 1'b1, 4'd5, 1'b0);

      // fetch stalled three cycles, then beq
      step("stall.f0", BEQ, 1'b0, 4'd1, 1'b0);
      step("stall.f1", BEQ, 1'b0, 4'd1, 1'b0);
      step("stall.f2", BEQ, 1'b0, 4'd1, 1'b0);
      step("stall.f3", BEQ, 1'b1, 4'd1, 1'b0);
      step("beq.d",    BEQ, 1'b1, 4'd2, 1'b0);
      step("beq.br",   BEQ, 1'b1, 4'd9, 1'b0);

      // jump
      step("j.f", JMP, 1'b1, 4'd1, 1'b0);
      step("j.d", JMP, 1'b1, 4'd2, 1'b0);
      step("j.j", JMP, 1'b1, 4'd10, 1'b0);

      // unsupported opcode pulses illegal_op in DECODE only
      step("bad.f", BAD, 1'b1, 4'd1, 1'b0);
      step("bad.d", BAD, 1'b1, 4'd2, 1'b1);

      // R-type then addi back to back
      step("r.f",   RTY, 1'b1, 4'd1, 1'b0);
      step("r.d",   RTY, 1'b1, 4'd2, 1'b0);
      step("r.ex",  RTY, 1'b1, 4'd7, 1'b0);
      step("r.wb",  RTY, 1'b1, 4'd8, 1'b0);
      step("ai.f",  ADDI, 1'b1, 4'd1, 1'b0);
      step("ai.d",  ADDI, 1'b1, 4'd2, 1'b0);
      step("ai.ex", ADDI, 1'b1, 4'd11, 1'b0);
      step("ai.wb", ADDI, 1'b1, 4'd12, 1'b0);

      // sw with a two-cycle memory wait
      step("sw.f",  SW, 1'b1, 4'd1, 1'b0);
      step("sw.d",  SW, 1'b1, 4'd2, 1'b0);
      step("sw.a",  SW, 1'b1, 4'd3, 1'b0);
      step("sw.w0", SW, 1'b0, 4'd6, 1'b0);
      step("sw.w1", SW, 1'b0, 4'd6, 1'b0);
      step("sw.w2", SW, 1'b1, 4'd6, 1'b0);

      // lw with a one-cycle read wait
      step("lw2.f",  LW, 1'b1, 4'd1, 1'b0);
      step("lw2.d",  LW, 1'b1, 4'd2, 1'b0);
      step("lw2.a",  LW, 1'b1, 4'd3, 1'b0);
      step("lw2.r0", LW, 1'b0, 4'd4, 1'b0);
      step("lw2.r1", LW, 1'b1, 4'd4, 1'b0);
      step("lw2.wb", LW, 1'b1, 4'd5, 1'b0);

      // reset asserted in the middle of a stalled MEM_WRITE
      step("sw2.f",  SW, 1'b1, 4'd1, 1'b0);
      step("sw2.d",  SW, 1'b1, 4'd2, 1'b0);
      step("sw2.a",  SW, 1'b1, 4'd3, 1'b0);
      step("sw2.w0", SW, 1'b0, 4'd6, 1'b0);
      #1 reset = 1'b1;
      #1;
      check("midrst.state", 32'(state), 32'd0);
      check("midrst.memwrite", 32'(MemWrite), 32'd0);
      check("midrst.ctrl", 32'(ctrl), 32'd0);
      @(posedge clk);
      #1;
      check("midrst.hold", 32'(state), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst.idle", 32'(state), 32'd0);
      check("midrst.idle_ctrl", 32'(ctrl), 32'd0);
      step("post.f", JMP, 1'b1, 4'd1, 1'b0);
      step("post.d", JMP, 1'b1, 4'd2, 1'b0);
      step("post.j", JMP, 1'b1, 4'd10, 1'b0);
      step("post.f2", RTY, 1'b1, 4'd1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore-style control state machine that sequences a multi-cycle MIPS datapath. It shares one ALU and one unified instruction/data memory across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK steps.
- Decodes the 6-bit opcode and drives every datapath mux, write-enable and ALU-op select once per step.
- Stalls on a memory-ready handshake.
- Flags unsupported opcodes.

Parameters:
- MEM_WAIT_EN, 1, 1 = honour mem_ready in memory states; 0 = treat mem_ready as always 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces state IDLE
- opcode  input  6  instruction bits [31:26] from the instruction register
- mem_ready  input  1  memory has completed the current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified externally by ALU zero flag (beq)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  destination register: 0 = rt [20:16], 1 = rd [15:11]
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- ALUOp  output  2  00 = add, 01 = subtract, 10 = use funct field
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], instr[25:0], 2'b00}
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- state  output  4  current state encoding, for debug and verification

Behaviour:
- State encoding:
  - IDLE = 0, FETCH = 1, DECODE = 2
  - MEM_ADDR = 3, MEM_READ = 4, MEM_WB = 5, MEM_WRITE = 6
  - R_EXEC = 7, R_WB = 8, BRANCH = 9, JUMP = 10
  - ADDI_EXEC = 11, ADDI_WB = 12
  - Encodings 13–15 are unused and return to FETCH.
- Reset (asynchronous): state = IDLE and every output = 0, including illegal_op. Reset mid-instruction aborts with no further strobes.
- IDLE: all outputs 0; next state is FETCH.
- FETCH:
  - Drives MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite and PCWrite = mem_ready.
  - Stays in FETCH while mem_ready = 0; moves to DECODE when mem_ready = 1.
- DECODE:
  - Drives ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (precomputes the branch target).
  - Next state by opcode:
    - 000000 -> R_EXEC
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDI_EXEC
    - any other opcode -> FETCH, with illegal_op = 1 for this cycle only
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead = 1, IorD = 1. Stays until mem_ready = 1, then goes to MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Next state is FETCH.
- MEM_WRITE:
  - MemWrite = 1, IorD = 1, held for the full wait.
  - Stays until mem_ready = 1, then goes to FETCH.
  - Exactly one cycle of MemWrite is seen with mem_ready = 1.
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next state is R_WB.
- R_WB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Next state is FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Next state is FETCH.
- JUMP: PCWrite = 1, PCSource = 10. Next state is FETCH.
- ADDI_EXEC: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state is ADDI_WB.
- ADDI_WB: RegWrite = 1, RegDst = 0, MemtoReg = 0. Next state is FETCH.
- Default values:
  - Any output not listed for a state is 0.
  - Outputs are a combinational function of state (plus mem_ready in FETCH) and are glitch-free relative to clk.
- Invariants:
  - MemRead and MemWrite are never high together.
  - RegWrite and PCWrite are never high together.
- Latency with mem_ready always 1 (cycles from FETCH):
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
- With MEM_WAIT_EN = 0, mem_ready is ignored and there are no stalls.

Test Plan:
1. Reset asserted mid-MEM_WRITE with mem_ready = 0 -> state = 0 and MemWrite = 0 immediately (asynchronous); after release, IDLE then FETCH on the next edges.
2. lw (opcode 100011), mem_ready = 1 -> state sequence 1, 2, 3, 4, 5, 1; RegWrite = 1 and MemtoReg = 1 only in state 5.
3. FETCH with mem_ready = 0 for 3 cycles, then 1 -> MemRead = 1 for 4 cycles; IRWrite and PCWrite = 1 only in the 4th; then DECODE.
4. beq (000100) -> BRANCH state has ALUOp = 01, PCWriteCond = 1, PCSource = 01, PCWrite = 0; j (000010) -> JUMP has PCWrite = 1, PCSource = 10.
5. opcode 111111 in DECODE -> illegal_op = 1 for exactly one cycle; next state FETCH; no RegWrite or MemWrite.
6. R-type then addi back-to-back -> R_WB has RegDst = 1; ADDI_WB has RegDst = 0 and ALUSrcB = 10 in the preceding ADDI_EXEC.
